// File: rtl/apb_pkg.sv
// Shared types and bus widths for the APB initiator.
package apb_pkg;
    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;
    localparam int APB_STRB_W = 4;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_mst_state_e;
endpackage

// File: rtl/apb_master_if.sv
// Request/response port and APB bus of the apb_master, bundled with direction views.
interface apb_master_if;
    import apb_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    logic [APB_ADDR_W-1:0] req_addr;
    logic                  req_write;
    logic [APB_DATA_W-1:0] req_wdata;
    logic [APB_STRB_W-1:0] req_wstrb;

    logic                  resp_valid;
    logic                  resp_ready;
    logic [APB_DATA_W-1:0] resp_rdata;
    logic                  resp_err;

    logic                  psel;
    logic                  penable;
    logic                  pready;
    logic [APB_ADDR_W-1:0] paddr;
    logic                  pwrite;
    logic [APB_DATA_W-1:0] pwdata;
    logic [APB_STRB_W-1:0] pwstrb;
    logic [APB_DATA_W-1:0] prdata;
    logic                  pslverr;

    modport master (
        input  req_valid, req_addr, req_write, req_wdata, req_wstrb,
        output req_ready,
        output resp_valid, resp_rdata, resp_err,
        input  resp_ready,
        output psel, penable, paddr, pwrite, pwdata, pwstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        output req_valid, req_addr, req_write, req_wdata, req_wstrb,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err,
        output resp_ready,
        input  psel, penable, paddr, pwrite, pwdata, pwstrb,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_master.sv
// APB initiator: one SETUP/ACCESS transfer per accepted request, with a
// held response and an optional ACCESS-phase timeout.
module apb_master
    import apb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_BW         = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic          clk,
    input  logic          rst,
    apb_master_if.master  bus
);
    // A disabled timeout yields a zero-width count; keep at least one bit.
    localparam int CW = (CNT_BW < 1) ? 1 : CNT_BW;

    apb_mst_state_e        state_q, state_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic [APB_ADDR_W-1:0] paddr_q, paddr_d;
    logic                  pwrite_q, pwrite_d;
    logic [APB_DATA_W-1:0] pwdata_q, pwdata_d;
    logic [APB_STRB_W-1:0] pwstrb_q, pwstrb_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [APB_DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic                  resp_err_q, resp_err_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  req_ready_w;
    logic                  timeout_hit;

    assign req_ready_w = (state_q == IDLE) && !rst;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d      = state_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        paddr_d      = paddr_q;
        pwrite_d     = pwrite_q;
        pwdata_d     = pwdata_q;
        pwstrb_d     = pwstrb_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        cnt_d        = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_w) begin
                    if (bus.req_addr[1:0] == 2'b00) begin
                        paddr_d   = bus.req_addr;
                        pwrite_d  = bus.req_write;
                        pwdata_d  = bus.req_wdata;
                        pwstrb_d  = bus.req_write ? bus.req_wstrb : '0;
                        psel_d    = 1'b1;
                        penable_d = 1'b0;
                        state_d   = SETUP;
                    end else begin
                        // Misaligned: answer with an error without touching the bus.
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                        state_d      = RESP;
                    end
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (bus.pready) begin
                    psel_d       = 1'b0;
                    penable_d    = 1'b0;
                    resp_rdata_d = (pwrite_q || bus.pslverr) ? '0 : bus.prdata;
                    resp_err_d   = bus.pslverr;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (timeout_hit) begin
                        psel_d       = 1'b0;
                        penable_d    = 1'b0;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                        resp_valid_d = 1'b1;
                        state_d      = RESP;
                    end
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            paddr_q      <= '0;
            pwrite_q     <= 1'b0;
            pwdata_q     <= '0;
            pwstrb_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            paddr_q      <= paddr_d;
            pwrite_q     <= pwrite_d;
            pwdata_q     <= pwdata_d;
            pwstrb_q     <= pwstrb_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.req_ready  = req_ready_w;
    assign bus.psel       = psel_q;
    assign bus.penable    = penable_q;
    assign bus.paddr      = paddr_q;
    assign bus.pwrite     = pwrite_q;
    assign bus.pwdata     = pwdata_q;
    assign bus.pwstrb     = pwstrb_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master against a small APB RAM slave with
// configurable wait states, error injection and a never-ready mode.
module tb_apb_master;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    apb_master_if bus();

    apb_master #(.TIMEOUT_CYCLES(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave controls, written only by the stimulus process.
    int   wait_states;
    logic err_inject;
    logic hang;

    logic [31:0] mem [0:255] = '{default: 32'h0};
    int          ws_cnt = 0;

    always @(negedge clk) begin
        if (bus.psel && bus.penable) begin
            if (hang) begin
                bus.pready  = 1'b0;
                bus.pslverr = 1'b0;
                bus.prdata  = 32'h0;
            end else if (ws_cnt == wait_states) begin
                bus.pready  = 1'b1;
                bus.pslverr = err_inject;
                bus.prdata  = mem[bus.paddr[9:2]];
                if (bus.pwrite && !err_inject) begin
                    for (int b = 0; b < 4; b++)
                        if (bus.pwstrb[b]) mem[bus.paddr[9:2]][8*b +: 8] = bus.pwdata[8*b +: 8];
                end
                ws_cnt = 0;
            end else begin
                bus.pready  = 1'b0;
                bus.pslverr = 1'b0;
                bus.prdata  = 32'h0;
                ws_cnt++;
            end
        end else begin
            bus.pready  = 1'b0;
            bus.pslverr = 1'b0;
            bus.prdata  = 32'h0;
            ws_cnt      = 0;
        end
    end

    // Bus activity counters and APB signal stability tracking.
    int          psel_total = 0;
    int          pen_total = 0;
    int          unstable_total = 0;
    logic        prev_psel = 1'b0;
    logic [31:0] prev_paddr = 32'h0;
    logic [31:0] prev_pwdata = 32'h0;
    logic [3:0]  prev_pwstrb = 4'h0;
    logic        prev_pwrite = 1'b0;

    always @(negedge clk) begin
        if (bus.psel) psel_total++;
        if (bus.penable) pen_total++;
        if (bus.psel && prev_psel &&
            (bus.paddr !== prev_paddr || bus.pwdata !== prev_pwdata ||
             bus.pwstrb !== prev_pwstrb || bus.pwrite !== prev_pwrite))
            unstable_total++;
        prev_psel   = bus.psel;
        prev_paddr  = bus.paddr;
        prev_pwdata = bus.pwdata;
        prev_pwstrb = bus.pwstrb;
        prev_pwrite = bus.pwrite;
    end

    logic [3:0] setup_pwstrb;

    task automatic do_req(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input bit consume,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output logic ok);
        ok    = 1'b1;
        lat   = 0;
        rdata = 32'h0;
        err   = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_write = wr;
        bus.req_wdata = wdata;
        bus.req_wstrb = wstrb;
        for (int n = 0; n < 20 && !bus.req_ready; n++) @(negedge clk);
        if (!bus.req_ready) begin
            ok = 1'b0;
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        setup_pwstrb  = bus.pwstrb;
        lat = 1;
        while (!bus.resp_valid && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!bus.resp_valid) begin
            ok = 1'b0;
            return;
        end
        rdata = bus.resp_rdata;
        err   = bus.resp_err;
        if (consume) begin
            @(negedge clk);
            bus.resp_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.resp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (bus.psel !== 1'b0 || bus.penable !== 1'b0 || bus.paddr !== 32'h0 ||
            bus.pwrite !== 1'b0 || bus.pwdata !== 32'h0 || bus.pwstrb !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_apb: psel=%b penable=%b paddr=%h pwrite=%b pwdata=%h pwstrb=%h, required all zero",
                     bus.psel, bus.penable, bus.paddr, bus.pwrite, bus.pwdata, bus.pwstrb);
        end
        n_tests++;
        if (bus.resp_valid !== 1'b0 || bus.resp_rdata !== 32'h0 || bus.resp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_resp: valid=%b rdata=%h err=%b, required 0/0/0",
                     bus.resp_valid, bus.resp_rdata, bus.resp_err);
        end
        n_tests++;
        if (bus.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_req_ready_in_rst: got %b, required 0", bus.req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_tests++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_req_ready_idle: got %b, required 1", bus.req_ready);
        end
    endtask

    task automatic test_write_read();
        logic [31:0] rd;
        logic        er;
        logic        ok;
        int          lat;
        int          p0;
        p0 = psel_total;
        do_req(32'h100, 1'b1, 32'hDEADBEEF, 4'hF, 1'b1, rd, er, lat, ok);
        n_tests++;
        if (!ok || lat != 3 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_basic: ok=%b lat=%0d err=%b, required ok=1 lat=3 err=0", ok, lat, er);
        end
        n_tests++;
        if (psel_total - p0 != 2) begin
            n_fail++;
            $display("FAIL wr_psel_cycles: got %0d, required 2", psel_total - p0);
        end
        p0 = psel_total;
        do_req(32'h100, 1'b0, 32'h0, 4'hF, 1'b1, rd, er, lat, ok);
        n_tests++;
        if (!ok || rd !== 32'hDEADBEEF || er !== 1'b0 || lat != 3) begin
            n_fail++;
            $display("FAIL rd_basic: ok=%b rdata=%h err=%b lat=%0d, required 1/deadbeef/0/3", ok, rd, er, lat);
        end
        n_tests++;
        if (psel_total - p0 != 2) begin
            n_fail++;
            $display("FAIL rd_psel_cycles: got %0d, required 2", psel_total - p0);
        end
    endtask

    task automatic test_strobes();
        logic [31:0] rd;
        logic        er;
        logic        ok;
        int          lat;
        do_req(32'h200, 1'b1, 32'hFFFFFFFF, 4'hF, 1'b1, rd, er, lat, ok);
        do_req(32'h200, 1'b1, 32'h11223344, 4'b0101, 1'b1, rd, er, lat, ok);
        n_tests++;
        if (setup_pwstrb !== 4'b0101) begin
            n_fail++;
            $display("FAIL strb_write_pwstrb: got %h, required 5", setup_pwstrb);
        end
        do_req(32'h200, 1'b0, 32'hCAFEF00D, 4'hF, 1'b1, rd, er, lat, ok);
        n_tests++;
        if (!ok || rd !== 32'hFF22FF44 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL strb_merge: ok=%b rdata=%h err=%b, required ff22ff44 err=0", ok, rd, er);
        end
        n_tests++;
        if (setup_pwstrb !== 4'h0) begin
            n_fail++;
            $display("FAIL strb_read_pwstrb: got %h, required 0", setup_pwstrb);
        end
    endtask

    task automatic test_wait_err();
        logic [31:0] rd;
        logic        er;
        logic        ok;
        int          lat;
        int          e0;
        int          u0;
        wait_states = 5;
        err_inject  = 1'b1;
        e0 = pen_total;
        u0 = unstable_total;
        do_req(32'h100, 1'b0, 32'h5A5A5A5A, 4'hF, 1'b1, rd, er, lat, ok);
        n_tests++;
        if (!ok || er !== 1'b1 || rd !== 32'h0) begin
            n_fail++;
            $display("FAIL wait_err_resp: ok=%b err=%b rdata=%h, required err=1 rdata=0", ok, er, rd);
        end
        n_tests++;
        if (pen_total - e0 != 6) begin
            n_fail++;
            $display("FAIL wait_penable_cycles: got %0d, required 6", pen_total - e0);
        end
        n_tests++;
        if (unstable_total != u0) begin
            n_fail++;
            $display("FAIL wait_stable: %0d changes while selected, required 0", unstable_total - u0);
        end
        wait_states = 0;
        err_inject  = 1'b0;
    endtask

    task automatic test_timeout();
        logic [31:0] rd;
        logic        er;
        logic        ok;
        int          lat;
        int          e0;
        hang = 1'b1;
        e0 = pen_total;
        do_req(32'h104, 1'b0, 32'h0, 4'hF, 1'b1, rd, er, lat, ok);
        n_tests++;
        if (!ok || er !== 1'b1 || rd !== 32'h0) begin
            n_fail++;
            $display("FAIL timeout_resp: ok=%b err=%b rdata=%h, required err=1 rdata=0", ok, er, rd);
        end
        n_tests++;
        if (pen_total - e0 != 8) begin
            n_fail++;
            $display("FAIL timeout_access_cycles: got %0d, required 8", pen_total - e0);
        end
        hang = 1'b0;
        do_req(32'h100, 1'b0, 32'h0, 4'hF, 1'b1, rd, er, lat, ok);
        n_tests++;
        if (!ok || rd !== 32'hDEADBEEF || er !== 1'b0 || lat != 3) begin
            n_fail++;
            $display("FAIL timeout_recover: ok=%b rdata=%h err=%b lat=%0d, required deadbeef/0/3", ok, rd, er, lat);
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] rd;
        logic        er;
        logic        ok;
        int          lat;
        int          p0;
        p0 = psel_total;
        do_req(32'h102, 1'b0, 32'h0, 4'hF, 1'b1, rd, er, lat, ok);
        n_tests++;
        if (!ok || lat != 1 || er !== 1'b1 || rd !== 32'h0) begin
            n_fail++;
            $display("FAIL misaligned_resp: ok=%b lat=%0d err=%b rdata=%h, required 1/1/1/0", ok, lat, er, rd);
        end
        n_tests++;
        if (psel_total != p0) begin
            n_fail++;
            $display("FAIL misaligned_psel: psel high %0d cycles, required 0", psel_total - p0);
        end
    endtask

    task automatic test_resp_hold();
        logic [31:0] rd;
        logic        er;
        logic        ok;
        int          lat;
        do_req(32'h200, 1'b0, 32'h0, 4'hF, 1'b0, rd, er, lat, ok);
        n_tests++;
        if (!ok || rd !== 32'hFF22FF44) begin
            n_fail++;
            $display("FAIL hold_first: ok=%b rdata=%h, required ff22ff44", ok, rd);
        end
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h300;
        bus.req_write = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_tests++;
            if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b1 ||
                bus.resp_rdata !== 32'hFF22FF44 || bus.resp_err !== 1'b0 || bus.psel !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: req_ready=%b valid=%b rdata=%h err=%b psel=%b, required 0/1/ff22ff44/0/0",
                         i, bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.resp_err, bus.psel);
            end
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        n_tests++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_release: valid=%b req_ready=%b, required 0/1", bus.resp_valid, bus.req_ready);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic        er;
        logic        ok;
        int          lat;
        int          seen;
        hang = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h108;
        bus.req_write = 1'b1;
        bus.req_wdata = 32'h12345678;
        bus.req_wstrb = 4'hF;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        n_tests++;
        if (bus.psel !== 1'b1 || bus.penable !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_access: psel=%b penable=%b, required 1/1", bus.psel, bus.penable);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if (bus.psel !== 1'b0 || bus.penable !== 1'b0 || bus.resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_abandon: psel=%b penable=%b valid=%b, required 0/0/0",
                     bus.psel, bus.penable, bus.resp_valid);
        end
        @(negedge clk);
        rst  = 1'b0;
        hang = 1'b0;
        #1;
        n_tests++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_idle: req_ready=%b, required 1", bus.req_ready);
        end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.resp_valid || bus.psel) seen++;
        end
        n_tests++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL rstmid_quiet: %0d active cycles, required 0", seen);
        end
        do_req(32'h100, 1'b0, 32'h0, 4'hF, 1'b1, rd, er, lat, ok);
        n_tests++;
        if (!ok || rd !== 32'hDEADBEEF || er !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_recover: ok=%b rdata=%h err=%b, required deadbeef/0", ok, rd, er);
        end
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        wait_states    = 0;
        err_inject     = 1'b0;
        hang           = 1'b0;
        setup_pwstrb   = 4'h0;
        bus.req_valid  = 1'b0;
        bus.req_addr   = 32'h0;
        bus.req_write  = 1'b0;
        bus.req_wdata  = 32'h0;
        bus.req_wstrb  = 4'h0;
        bus.resp_ready = 1'b0;
        test_reset();
        test_write_read();
        test_strobes();
        test_wait_err();
        test_timeout();
        test_misaligned();
        test_resp_hold();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
